// File: rtl/ring_mod_pkg.sv
// ----------------------------------------------------------------------------
// ring_mod_pkg
// Shared widths and types for the ring-modulator carrier generator.
//   DEF_PHASE_W   default phase accumulator / freq_word width
//   DEF_ADDR_W    default quarter-wave ROM address width
//   DEF_LUT_W     default ROM entry width (unsigned magnitude)
//   DEF_FRAC_BITS default carrier fractional bits
//   phase_t       phase accumulator word
//   carrier_t     signed carrier sample handed to the modulator
//   quadrant_t    top two phase bits selecting the sine quadrant
// ----------------------------------------------------------------------------
package ring_mod_pkg;

    localparam int DEF_PHASE_W   = 32;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_LUT_W     = 16;
    localparam int DEF_FRAC_BITS = 4;
    localparam int CARRIER_W     = 32;

    typedef logic [DEF_PHASE_W-1:0]      phase_t;
    typedef logic signed [CARRIER_W-1:0] carrier_t;
    typedef logic [1:0]                  quadrant_t;

endpackage

// File: rtl/ring_mod_carrier_gen_quarter_sine_rom.sv
// ----------------------------------------------------------------------------
// quarter_sine_rom
// Quarter-wave sine magnitude table with a registered one-cycle read.
// Entry i holds round((2^(LUT_W-1)-1) * sin(pi/2 * (i+0.5)/2^ADDR_W)); the
// half-step offset lets the other three quadrants be produced by index
// inversion and negation with no duplicated peak or zero entry.
// Ports:
//   clk   in   1       clock
//   en    in   1       read enable; data holds its value when low
//   addr  in   ADDR_W  table index
//   data  out  LUT_W   registered magnitude
// ----------------------------------------------------------------------------
module quarter_sine_rom #(
    parameter int ADDR_W = 8,
    parameter int LUT_W  = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [LUT_W-1:0]  data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Elaboration-time sine via a short Taylor series; x stays within
    // [0, pi/2] so ten terms are far below one LSB of error.
    function automatic logic [LUT_W-1:0] rom_entry(input int i);
        real x;
        real term;
        real acc;
        real amp;
        x    = 1.5707963267948966 * (real'(i) + 0.5) / real'(DEPTH);
        term = x;
        acc  = x;
        for (int k = 1; k < 10; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        amp = real'((1 << (LUT_W - 1)) - 1);
        return LUT_W'($rtoi(acc * amp + 0.5));
    endfunction

    logic [LUT_W-1:0] rom_w [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam logic [LUT_W-1:0] ENTRY = rom_entry(g);
        assign rom_w[g] = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data <= rom_w[addr];
        end
    end

endmodule

// File: rtl/ring_mod_carrier_gen.sv
// ----------------------------------------------------------------------------
// ring_mod_carrier_gen
// Sine carrier source for the ring modulator. A phase accumulator advances on
// every audio sample tick; a quarter-wave ROM with quadrant mirroring turns
// the phase into a signed amplitude scaled so +/-2^FRAC_BITS is unity gain.
// Ports:
//   clk          in   1        clock
//   rst_n        in   1        synchronous reset, active-low
//   sample_tick  in   1        one-cycle strobe at the audio sample rate
//   phase_clr    in   1        one-cycle strobe forcing the phase to zero
//   freq_word    in   PHASE_W  phase increment per tick
//   freq_valid   in   1        freq_word valid
//   freq_ready   out  1        a new freq_word can be accepted
//   sin          out  32       signed carrier sample, held between pulses
//   sin_valid    out  1        one-cycle pulse two cycles after each tick
// ----------------------------------------------------------------------------
module ring_mod_carrier_gen
    import ring_mod_pkg::*;
#(
    parameter int                 PHASE_W    = DEF_PHASE_W,
    parameter int                 ADDR_W     = DEF_ADDR_W,
    parameter int                 LUT_W      = DEF_LUT_W,
    parameter int                 FRAC_BITS  = DEF_FRAC_BITS,
    parameter logic [PHASE_W-1:0] RESET_FREQ = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               freq_valid,
    output logic               freq_ready,
    output carrier_t           sin,
    output logic               sin_valid
);

    localparam int SHIFT = LUT_W - 1 - FRAC_BITS;

    // Magnitude -> signed carrier: sign-extend, apply quadrant sign, then
    // drop to FRAC_BITS fractional bits with an arithmetic (floor) shift.
    function automatic carrier_t scale_carrier(input logic [LUT_W-1:0] mag,
                                               input logic             neg);
        carrier_t s;
        s = signed'(32'(mag));
        if (neg) begin
            s = -s;
        end
        return s >>> SHIFT;
    endfunction

    logic [PHASE_W-1:0] phase_p0;
    logic [PHASE_W-1:0] phase_next;
    logic [PHASE_W-1:0] freq_active;
    logic [PHASE_W-1:0] freq_pending;
    logic               pending;

    quadrant_t          q_p1;
    logic [ADDR_W-1:0]  idx_p1;
    logic               vld_p1;

    logic               neg_p2;
    logic               vld_p2;
    logic               have_p2;

    logic [ADDR_W-1:0]  rom_addr;
    logic [LUT_W-1:0]   rom_q;

    // Held low during reset so no word is taken while the block is cleared.
    assign freq_ready = rst_n & ~pending;

    // ---- stage 0: phase accumulator ----
    always_comb begin
        phase_next = phase_clr ? '0 : phase_p0 + freq_active;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_p0    <= '0;
            freq_active <= RESET_FREQ;
            pending     <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            have_p2     <= 1'b0;
        end else begin
            if (sample_tick || phase_clr) begin
                phase_p0 <= phase_next;
            end
            // A tick promotes the pending word after this tick's phase step
            // has already used the old increment. A transfer can only happen
            // while nothing is pending, so the two branches never collide.
            if (sample_tick && pending) begin
                freq_active <= freq_pending;
                pending     <= 1'b0;
            end else if (freq_valid && freq_ready) begin
                pending <= 1'b1;
            end
            vld_p1 <= sample_tick;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                have_p2 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (freq_valid && freq_ready) begin
            freq_pending <= freq_word;
        end
        if (sample_tick) begin
            q_p1   <= phase_next[PHASE_W-1 -: 2];
            idx_p1 <= phase_next[PHASE_W-3 -: ADDR_W];
        end
        if (vld_p1) begin
            neg_p2 <= q_p1[1];
        end
    end

    // ---- stage 1 -> 2: quadrant mirroring and registered ROM read ----
    // Odd quadrants walk the table backwards; the lower half-cycle negates.
    assign rom_addr = q_p1[0] ? ~idx_p1 : idx_p1;

    quarter_sine_rom #(
        .ADDR_W (ADDR_W),
        .LUT_W  (LUT_W)
    ) u_rom (
        .clk  (clk),
        .en   (vld_p1),
        .addr (rom_addr),
        .data (rom_q)
    );

    // ---- stage 2: output scaling ----
    // ROM data and sign only move on a new sample, so sin holds between
    // pulses; it reads zero until the first sample after reset.
    assign sin       = have_p2 ? scale_carrier(rom_q, neg_p2) : '0;
    assign sin_valid = vld_p2;

endmodule

// File: tb/tb_ring_mod_carrier_gen.sv
// ----------------------------------------------------------------------------
// tb_ring_mod_carrier_gen
// Directed, table-driven bench for ring_mod_carrier_gen with hand-computed
// carrier values and a small sine model for the continuous-tick run.
// ----------------------------------------------------------------------------
module tb_ring_mod_carrier_gen;
    import ring_mod_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     sample_tick;
    logic     phase_clr;
    phase_t   freq_word;
    logic     freq_valid;
    logic     freq_ready;
    carrier_t sin;
    logic     sin_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ring_mod_carrier_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .phase_clr   (phase_clr),
        .freq_word   (freq_word),
        .freq_valid  (freq_valid),
        .freq_ready  (freq_ready),
        .sin         (sin),
        .sin_valid   (sin_valid)
    );

    typedef struct {
        string  name;
        logic   tick;
        logic   clr;
        logic   fv;
        phase_t fw;
        logic   exp_vld;
        int     exp_sin;
    } vec_t;

    function automatic vec_t mk(input string name, input logic tick, input logic clr,
                                input logic fv, input phase_t fw,
                                input logic exp_vld, input int exp_sin);
        vec_t v;
        v.name = name; v.tick = tick; v.clr = clr; v.fv = fv; v.fw = fw;
        v.exp_vld = exp_vld; v.exp_sin = exp_sin;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ideal carrier for a 32-bit phase: full-cycle sine sampled at the
    // centre of its 10-bit bucket, rounded to 16-bit amplitude, >>> 11.
    function automatic int model(input logic [31:0] ph);
        real a;
        real r;
        int  m;
        a = 6.283185307179586 * (real'(int'(ph[31:22])) + 0.5) / 1024.0;
        r = $sin(a) * 32767.0;
        m = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        return m >>> 11;
    endfunction

    // One cycle of stimulus, then check the pulse lands exactly two edges
    // later and that sin holds for the cycle after it.
    task automatic apply(input vec_t v);
        sample_tick = v.tick;
        phase_clr   = v.clr;
        freq_valid  = v.fv;
        freq_word   = v.fw;
        step();
        sample_tick = 1'b0;
        phase_clr   = 1'b0;
        freq_valid  = 1'b0;
        check({v.name, "_early"}, int'(sin_valid), 0);
        step();
        check({v.name, "_vld"}, int'(sin_valid), int'(v.exp_vld));
        if (v.exp_vld) check({v.name, "_sin"}, int'(sin), v.exp_sin);
        step();
        check({v.name, "_pulse_end"}, int'(sin_valid), 0);
        if (v.exp_vld) check({v.name, "_hold"}, int'(sin), v.exp_sin);
    endtask

    vec_t tbl [14];
    int   prev;

    initial begin
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        phase_clr   = 1'b0;
        freq_valid  = 1'b0;
        freq_word   = '0;

        // ---- 1: reset ----
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_sin", int'(sin), 0);
            check("rst_vld", int'(sin_valid), 0);
            check("rst_ready", int'(freq_ready), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_ready", int'(freq_ready), 1);
            check("post_rst_vld", int'(sin_valid), 0);
        end

        // ---- 2 and 4: quarter-turn stepping, wrap and clear ----
        tbl[0]  = mk("t2_load",     0, 0, 1, 32'h4000_0000, 0, 0);
        tbl[1]  = mk("t2_tick0",    1, 0, 0, '0, 1, 0);
        tbl[2]  = mk("t2_tick1",    1, 0, 0, '0, 1, 15);
        tbl[3]  = mk("t2_tick2",    1, 0, 0, '0, 1, -1);
        tbl[4]  = mk("t2_tick3",    1, 0, 0, '0, 1, -16);
        tbl[5]  = mk("t2_tick4",    1, 0, 0, '0, 1, 0);
        tbl[6]  = mk("t4_load",     0, 0, 1, 32'hC000_0000, 0, 0);
        tbl[7]  = mk("t4_clr_tick", 1, 1, 0, '0, 1, 0);
        tbl[8]  = mk("t4_wrap_c",   1, 0, 0, '0, 1, -16);
        tbl[9]  = mk("t4_wrap_8",   1, 0, 0, '0, 1, -1);
        tbl[10] = mk("t4_wrap_4",   1, 0, 0, '0, 1, 15);
        tbl[11] = mk("t4_clr_only", 0, 1, 0, '0, 0, 0);
        tbl[12] = mk("t4_after_clr",1, 0, 0, '0, 1, -16);
        tbl[13] = mk("t4_clr_tick2",1, 1, 0, '0, 1, 0);
        for (int i = 0; i < 14; i++) apply(tbl[i]);

        // ---- 3: handshake (phase 0, active C000_0000) ----
        apply(mk("t3_load_a", 0, 0, 1, 32'h4000_0000, 0, 0));
        check("t3_ready_pending", int'(freq_ready), 0);
        freq_valid = 1'b1;
        freq_word  = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_held_off", int'(freq_ready), 0);
        end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("t3_ready_after_tick", int'(freq_ready), 1);
        step();
        freq_valid = 1'b0;
        check("t3_captured", int'(freq_ready), 0);
        check("t3_old_freq_vld", int'(sin_valid), 1);
        check("t3_old_freq_sin", int'(sin), -16);
        step();
        apply(mk("t3_freq_a",    1, 0, 0, '0, 1, 0));
        apply(mk("t3_freq_b",    1, 0, 0, '0, 1, -1));
        apply(mk("t3_same_cyc",  1, 0, 1, 32'h4000_0000, 1, 0));
        apply(mk("t3_still_b",   1, 0, 0, '0, 1, -1));
        apply(mk("t3_now_d",     1, 0, 0, '0, 1, -16));

        // ---- 5: continuous ticks ----
        apply(mk("t5_clr",  0, 1, 0, '0, 0, 0));
        apply(mk("t5_load", 0, 0, 1, 32'h0100_0000, 0, 0));
        sample_tick = 1'b1;
        phase_clr   = 1'b1;
        prev = -100;
        for (int c = 0; c < 82; c++) begin
            step();
            phase_clr = 1'b0;
            if (c == 79) sample_tick = 1'b0;
            if (c == 0 || c == 81) begin
                check("t5_fill_edge", int'(sin_valid), 0);
            end else begin
                check("t5_vld", int'(sin_valid), 1);
                check("t5_sin", int'(sin), model(32'((c - 1) * 32'h0100_0000)));
                if (c - 1 < 64) check("t5_monotonic", int'(int'(sin) >= prev), 1);
                prev = int'(sin);
            end
        end

        // ---- 6: reset with samples in flight ----
        apply(mk("t6_clr_tick", 1, 1, 0, '0, 1, 0));
        apply(mk("t6_load",     0, 0, 1, 32'h4000_0000, 0, 0));
        apply(mk("t6_activate", 1, 1, 0, '0, 1, 0));
        apply(mk("t6_pend",     0, 0, 1, 32'h8000_0000, 0, 0));
        sample_tick = 1'b1;
        step();
        step();
        sample_tick = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t6_rst_vld", int'(sin_valid), 0);
            check("t6_rst_sin", int'(sin), 0);
            check("t6_rst_ready", int'(freq_ready), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_flush_vld", int'(sin_valid), 0);
            check("t6_flush_sin", int'(sin), 0);
            check("t6_ready", int'(freq_ready), 1);
        end
        apply(mk("t6_freq_reset1", 1, 0, 0, '0, 1, 0));
        apply(mk("t6_freq_reset2", 1, 0, 0, '0, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
